// File: rtl/step_tick_pkg.sv
// Shared types and defaults for the step tick generator.
// Holds the speed index type, the debounce FSM encoding and the
// default timing values used by step_tick_gen and btn_debounce.
package step_tick_pkg;

    // Speed index 0..3; tick period is TICK_DIV_SLOW >> speed
    typedef logic [1:0] speed_t;

    // Debounce FSM states
    typedef enum logic [1:0] {
        DB_RELEASED     = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_HELD         = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_t;

    // Defaults sized for a 25 MHz board clock
    localparam int unsigned TICK_DIV_SLOW_DEF = 25_000_000;
    localparam int unsigned DEBOUNCE_CYC_DEF  = 1_000_000;

    // Tick period for a speed index, never below one cycle
    function automatic logic [31:0] tick_period(input logic [31:0] div,
                                                input speed_t      spd);
        logic [31:0] p;
        p = div >> spd;
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a
// four-state debounce FSM. LEVEL is the accepted button level and
// PRESS pulses for one cycle when a press is accepted.
module btn_debounce
    import step_tick_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic LEVEL,
    output logic PRESS
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_1, sync_2;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Two-flop synchronizer for the asynchronous raw button
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!RST) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= BTN;
            sync_2 <= sync_1;
        end
    end

    // Debounce state and stability counter registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= DB_RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a level must hold DEBOUNCE_CYC cycles in a WAIT state
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        PRESS   = 1'b0;
        case (state_q)
            DB_RELEASED: begin
                if (sync_2) begin
                    state_d = DB_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            DB_PRESS_WAIT: begin
                if (!sync_2) begin
                    state_d = DB_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_HELD;
                    cnt_d   = '0;
                    PRESS   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DB_HELD: begin
                if (!sync_2) begin
                    state_d = DB_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            DB_RELEASE_WAIT: begin
                if (sync_2) begin
                    state_d = DB_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DB_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign LEVEL = (state_q == DB_HELD) || (state_q == DB_RELEASE_WAIT);

endmodule

// File: rtl/step_tick_gen.sv
// Step tick generator: a prescaler emits a one-cycle TICK every
// TICK_DIV_SLOW >> SPEED cycles. A debounced speed button steps SPEED
// 0..3 (wrapping). Build macro STEP_TICK_PAUSE_EN adds a debounced
// pause button that toggles RUNNING; without it BTN_PAUSE is ignored
// and RUNNING is tied high.
module step_tick_gen
    import step_tick_pkg::*;
#(
    parameter int unsigned TICK_DIV_SLOW = TICK_DIV_SLOW_DEF,
    parameter int unsigned DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_SPEED,
    input  logic       BTN_PAUSE,
    output logic       TICK,
    output logic [1:0] SPEED,
    output logic       RUNNING
);

    logic        speed_evt;
    logic        speed_level_unused;
    logic        pause_evt;
    logic        running;
    speed_t      speed_q;
    logic [31:0] cnt_q;
    logic [31:0] period;
    logic        terminal;
    logic        tick_q;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_speed_db (
        .CLK   (CLK),
        .RST   (RST),
        .BTN   (BTN_SPEED),
        .LEVEL (speed_level_unused),
        .PRESS (speed_evt)
    );

`ifdef STEP_TICK_PAUSE_EN
    logic pause_level_unused;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_pause_db (
        .CLK   (CLK),
        .RST   (RST),
        .BTN   (BTN_PAUSE),
        .LEVEL (pause_level_unused),
        .PRESS (pause_evt)
    );

    // Pause press toggles the run state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            running <= 1'b1;
        end else if (pause_evt) begin
            running <= ~running;
        end
    end
`else
    logic pause_unused;

    assign pause_unused = BTN_PAUSE;
    assign pause_evt    = 1'b0;
    assign running      = 1'b1;
`endif

    assign period   = tick_period(TICK_DIV_SLOW, speed_q);
    assign terminal = (cnt_q >= period - 32'd1);

    // Speed index, prescaler and registered tick; a speed press overrides terminal count
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            speed_q <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else if (speed_evt) begin
            speed_q <= speed_q + 2'd1;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else if (running) begin
            if (terminal) begin
                cnt_q  <= '0;
                tick_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + 32'd1;
                tick_q <= 1'b0;
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

    assign TICK    = tick_q;
    assign SPEED   = speed_q;
    assign RUNNING = running;

endmodule

// File: tb/tb_step_tick_gen.sv
// Scoreboard bench for step_tick_gen (TICK_DIV_SLOW=16, DEBOUNCE_CYC=4).
// The whole expected TICK schedule is pushed up front from a fixed
// stimulus timeline; a monitor pops and compares on every TICK.
module tb_step_tick_gen;

`ifdef STEP_TICK_PAUSE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       BTN_SPEED = 1'b0;
    logic       BTN_PAUSE = 1'b0;
    logic       TICK;
    logic [1:0] SPEED;
    logic       RUNNING;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [1:0] spd;
        logic       run;
    } exp_t;

    exp_t exp_q[$];

    step_tick_gen #(
        .TICK_DIV_SLOW (16),
        .DEBOUNCE_CYC  (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .BTN_SPEED (BTN_SPEED),
        .BTN_PAUSE (BTN_PAUSE),
        .TICK      (TICK),
        .SPEED     (SPEED),
        .RUNNING   (RUNNING)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ticks at s+p, s+2p, ... strictly below lim
    task automatic push_ticks(input int s, input int p, input int lim, input logic [1:0] spd);
        for (int t = s + p; t < lim; t += p) begin
            exp_t e;
            e.cyc = t;
            e.spd = spd;
            e.run = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    // Press at negedge of cycle k; event edge is k+7; hold 10 cycles
    task automatic do_press(input int k, input bit bs, input bit bp,
                            input logic [1:0] spd_b, input logic [1:0] spd_a,
                            input logic run_b, input logic run_a);
        wait_cyc(k);
        BTN_SPEED = bs;
        BTN_PAUSE = bp;
        wait_cyc(k + 6);
        check("speed_before_evt", {30'd0, SPEED}, {30'd0, spd_b});
        check("running_before_evt", {31'd0, RUNNING}, {31'd0, run_b});
        wait_cyc(k + 7);
        check("speed_after_evt", {30'd0, SPEED}, {30'd0, spd_a});
        check("running_after_evt", {31'd0, RUNNING}, {31'd0, run_a});
        wait_cyc(k + 10);
        BTN_SPEED = 1'b0;
        BTN_PAUSE = 1'b0;
    endtask

    // Monitor: every TICK must match the head of the expected schedule
    always @(negedge CLK) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL tick_missing: none at cycle %0d, required TICK there", exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (TICK) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL tick_unexpected: TICK=1 at cycle %0d, required 0", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("tick_cycle", cyc, e.cyc);
                    check("tick_speed", {30'd0, SPEED}, {30'd0, e.spd});
                    check("tick_running", {31'd0, RUNNING}, {31'd0, e.run});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int r, k1, e1, e2, e3, e4, kp, ep, kr, er, ks, es, ka, ea, kr2, er2, t_end;

        // Reset state
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_tick", {31'd0, TICK}, 32'd0);
        check("reset_speed", {30'd0, SPEED}, 32'd0);
        check("reset_running", {31'd0, RUNNING}, 32'd1);

        RST = 1'b1;
        r   = cyc;

        // Fixed timeline of event edges
        k1  = r + 80;    e1  = k1 + 7;
        e2  = e1 + 47;   e3  = e2 + 47;   e4 = e3 + 47;
        kp  = e4 + 47;   ep  = kp + 7;
        kr  = ep + 100;  er  = kr + 7;
        ks  = er + 35;   es  = ks + 7;
        ka  = es + 20;   ea  = ka + 7;
        kr2 = ea + 20;   er2 = kr2 + 7;
        t_end = PE ? (er2 + 28) : (ea + 56);

        push_ticks(r,  16, e1, 2'd0);
        push_ticks(e1, 8,  e2, 2'd1);
        push_ticks(e2, 4,  e3, 2'd2);
        push_ticks(e3, 2,  e4, 2'd3);
        if (PE) begin
            push_ticks(e4, 16, ep, 2'd0);
            push_ticks(er - 6, 16, es, 2'd0);
            push_ticks(er2, 4, t_end + 1, 2'd2);
        end else begin
            push_ticks(e4, 16, es, 2'd0);
            push_ticks(es, 8, ea, 2'd1);
            push_ticks(ea, 4, t_end + 1, 2'd2);
        end
        mon_en = 1'b1;

        // Bouncy speed button: 3 high / 1 low for 40 cycles, never accepted
        wait_cyc(r + 20);
        for (int i = 0; i < 40; i++) begin
            BTN_SPEED = (i % 4) != 3;
            @(negedge CLK);
        end
        BTN_SPEED = 1'b0;
        wait_cyc(r + 70);
        check("bounce_speed", {30'd0, SPEED}, 32'd0);

        // Four clean speed presses: 1, 2, 3, wrap to 0
        do_press(k1,      1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1);
        do_press(e1 + 40, 1'b1, 1'b0, 2'd1, 2'd2, 1'b1, 1'b1);
        do_press(e2 + 40, 1'b1, 1'b0, 2'd2, 2'd3, 1'b1, 1'b1);
        do_press(e3 + 40, 1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 1'b1);

        // Pause at counter 5, hold 100 cycles, resume
        do_press(kp, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, !PE);
        do_press(kr, 1'b0, 1'b1, 2'd0, 2'd0, !PE, 1'b1);

        // Speed and pause together at counter 15
        do_press(ks, 1'b1, 1'b1, 2'd0, 2'd1, 1'b1, !PE);

        // Speed change while paused, then resume from cleared counter
        do_press(ka,  1'b1, 1'b0, 2'd1, 2'd2, !PE, !PE);
        do_press(kr2, 1'b0, 1'b1, 2'd2, 2'd2, !PE, 1'b1);

        // Asynchronous reset between edges while TICK is high
        wait_cyc(t_end);
        #2;
        RST = 1'b0;
        #1;
        check("async_rst_tick", {31'd0, TICK}, 32'd0);
        check("async_rst_speed", {30'd0, SPEED}, 32'd0);
        check("async_rst_running", {31'd0, RUNNING}, 32'd1);
        repeat (3) @(negedge CLK);
        check("sched_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/step_tick_gen.md
STEP_TICK_GEN -- requirements
Module: step_tick_gen

Interface
REQ-001 SHALL have parameter TICK_DIV_SLOW, default 25_000_000: clock cycles per TICK at speed index 0.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 1_000_000: cycles a synchronized button level must stay stable to be accepted.
REQ-003 SHALL have port CLK  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port BTN_SPEED  in  1  raw speed push button, active-high, asynchronous to CLK, bouncy.
REQ-006 SHALL have port BTN_PAUSE  in  1  raw pause push button, active-high, asynchronous, bouncy.
REQ-007 SHALL have port TICK  out  1  one-cycle step enable for the downstream LED fill/empty pattern stage.
REQ-008 SHALL have port SPEED  out  2  current speed index 0..3.
REQ-009 SHALL have port RUNNING  out  1  high = ticking, low = paused.

Function
REQ-010 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-011 SHALL debounce each synchronized button with a 4-state FSM: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-012 RELEASED->PRESS_WAIT on level 1; PRESS_WAIT->HELD after DEBOUNCE_CYC consecutive 1s, else back to RELEASED on any 0 (counter cleared).
REQ-013 HELD->RELEASE_WAIT on level 0; RELEASE_WAIT->RELEASED after DEBOUNCE_CYC consecutive 0s, else back to HELD on any 1.
REQ-014 SHALL emit exactly one single-cycle press event on the PRESS_WAIT->HELD transition; none on release.
REQ-015 Speed event SHALL increment SPEED modulo 4 (3 wraps to 0) and clear the prescaler counter in the same cycle.
REQ-016 Tick period SHALL be TICK_DIV_SLOW >> SPEED cycles (divide by 1, 2, 4, 8); period computed with width of TICK_DIV_SLOW, minimum period 1.
REQ-017 Prescaler counts 0..period-1 while RUNNING; at period-1 TICK SHALL assert for exactly one cycle and the counter wraps to 0.
REQ-018 Pause event SHALL toggle RUNNING; while RUNNING=0 the counter holds its value and TICK stays 0.
REQ-019 On resume, counting SHALL continue from the held value (no restart).
REQ-020 Speed event coinciding with terminal count: speed wins, counter clears, no TICK that cycle.
REQ-021 Simultaneous speed and pause events SHALL both be applied in the same cycle.
REQ-022 Speed change while paused SHALL update SPEED and clear the counter; TICK stays 0.

Reset
REQ-023 RST low SHALL immediately, without a clock edge, force TICK=0, SPEED=0, RUNNING=1, prescaler=0, synchronizers=0, both FSMs=RELEASED with counters 0.
REQ-024 Reset asserted mid-press SHALL discard the press; a still-held button after release of RST SHALL be re-debounced from RELEASED.

Configuration
REQ-025 Macro STEP_TICK_PAUSE_EN defined: pause path (REQ-006, REQ-018, REQ-019, REQ-021, REQ-022) fully present.
REQ-026 Macro STEP_TICK_PAUSE_EN undefined: BTN_PAUSE port kept but ignored, no pause debouncer instantiated, RUNNING tied 1.

Structure
REQ-027 Shared package step_tick_pkg SHALL hold: 2-bit speed index type, debounce FSM state encoding, default values for TICK_DIV_SLOW and DEBOUNCE_CYC.
REQ-028 Debounce FSM plus synchronizer SHALL be sub-module btn_debounce (parameter DEBOUNCE_CYC, outputs debounced level and press pulse), instantiated once per button.

Verification (TICK_DIV_SLOW=16, DEBOUNCE_CYC=4, macro defined unless stated)
REQ-029 Release RST, no buttons -> first TICK 16 cycles after first edge, then every 16 cycles, SPEED=0, RUNNING=1.
REQ-030 BTN_SPEED held 10 cycles -> exactly one event within 2+4+1 cycles of press, SPEED=1, TICK period 8 measured from event; repeat three presses -> SPEED 2,3,0 with periods 4,2,16.
REQ-031 BTN_SPEED toggling 3 cycles high / 1 low for 40 cycles -> no event, SPEED stays 0.
REQ-032 Pause press at counter=5 -> RUNNING=0, no TICK for 100 cycles; second press -> RUNNING=1, next TICK 10 cycles after resume.
REQ-033 Speed and pause events forced in the same cycle at counter=15 -> SPEED increments, RUNNING toggles, counter=0, no TICK.
REQ-034 RST pulled low mid-count between clock edges -> TICK=0, SPEED=0, RUNNING=1 immediately; macro undefined build -> BTN_PAUSE presses leave RUNNING=1.
